// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter.
// Policy is selected by MEM_ARBITER_RR_EN (see mem_arbiter_pick).
package arb_types;

  typedef enum logic [1:0] {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D} arb_state_t;
  typedef enum logic       {ARB_SRC_I, ARB_SRC_D}                arb_src_t;
  typedef enum logic       {ARB_OP_READ, ARB_OP_WRITE}           arb_op_t;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  // An illegal read+write request is treated as a write.
  function automatic arb_op_t op_of(input logic wr);
    return wr ? ARB_OP_WRITE : ARB_OP_READ;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and response signals of the arbiter.
// master = arbiter view, slave = requesters/memory view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic              i_read, i_write;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic [MASK_W-1:0] i_wmask;
  logic [DATA_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read, d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [MASK_W-1:0] d_wmask;
  logic [DATA_W-1:0] d_rdata;
  logic              d_resp;

  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_byte_enable;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;

  modport master (
    input  i_read, i_write, i_addr, i_wdata, i_wmask,
    output i_rdata, i_resp,
    input  d_read, d_write, d_addr, d_wdata, d_wmask,
    output d_rdata, d_resp,
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_rdata, mem_resp
  );

  modport slave (
    output i_read, i_write, i_addr, i_wdata, i_wmask,
    input  i_rdata, i_resp,
    output d_read, d_write, d_addr, d_wdata, d_wmask,
    input  d_rdata, d_resp,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational winner select. MEM_ARBITER_RR_EN: ties alternate using
// last_src; otherwise the data side wins every tie.
module mem_arbiter_pick
  import arb_types::*;
(
  input  logic     i_req,
  input  logic     d_req,
`ifdef MEM_ARBITER_RR_EN
  input  arb_src_t last_src,
`endif
  output logic     grant,
  output arb_src_t winner
);

  always_comb begin
    grant  = i_req | d_req;
    winner = ARB_SRC_D;
    if (i_req && !d_req) begin
      winner = ARB_SRC_I;
    end else if (i_req && d_req) begin
`ifdef MEM_ARBITER_RR_EN
      winner = (last_src == ARB_SRC_D) ? ARB_SRC_I : ARB_SRC_D;
`else
      winner = ARB_SRC_D;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction and data requesters.
// Optional round-robin tie-break with MEM_ARBITER_RR_EN.
module mem_arbiter
  import arb_types::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus,
  output logic          busy
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_t state;
  logic       i_req, d_req, grant;
  arb_src_t   winner;
  arb_op_t    win_op;

  assign i_req = bus.i_read | bus.i_write;
  assign d_req = bus.d_read | bus.d_write;

`ifdef MEM_ARBITER_RR_EN
  arb_src_t last_src;
`endif

  mem_arbiter_pick u_pick (
    .i_req    (i_req),
    .d_req    (d_req),
`ifdef MEM_ARBITER_RR_EN
    .last_src (last_src),
`endif
    .grant    (grant),
    .winner   (winner)
  );

  assign win_op = op_of((winner == ARB_SRC_D) ? bus.d_write : bus.i_write);

  // Memory command is only ever driven from these registers; the
  // requesters' live inputs are ignored once a grant is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ARB_IDLE;
      bus.mem_read        <= 1'b0;
      bus.mem_write       <= 1'b0;
      bus.mem_address     <= '0;
      bus.mem_wdata       <= '0;
      bus.mem_byte_enable <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_src            <= ARB_SRC_I;
`endif
    end else begin
      case (state)
        ARB_IDLE: if (grant) begin
          state         <= (winner == ARB_SRC_D) ? ARB_SERVE_D : ARB_SERVE_I;
          bus.mem_read  <= (win_op == ARB_OP_READ);
          bus.mem_write <= (win_op == ARB_OP_WRITE);
          if (winner == ARB_SRC_D) begin
            bus.mem_address     <= bus.d_addr;
            bus.mem_wdata       <= bus.d_wdata;
            bus.mem_byte_enable <= bus.d_wmask;
          end else begin
            bus.mem_address     <= bus.i_addr;
            bus.mem_wdata       <= bus.i_wdata;
            bus.mem_byte_enable <= bus.i_wmask;
          end
`ifdef MEM_ARBITER_RR_EN
          last_src <= winner;
`endif
        end
        ARB_SERVE_I, ARB_SERVE_D: if (bus.mem_resp) begin
          // Forced return to IDLE guarantees a gap cycle between grants.
          state         <= ARB_IDLE;
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b0;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign busy        = (state != ARB_IDLE);
  assign bus.i_resp  = (state == ARB_SERVE_I) & bus.mem_resp;
  assign bus.d_resp  = (state == ARB_SERVE_D) & bus.mem_resp;
  assign bus.i_rdata = (state == ARB_SERVE_I) ? bus.mem_rdata : '0;
  assign bus.d_rdata = (state == ARB_SERVE_D) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against a transaction-level
// model of who owns the memory port and what command it carries.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: owner 0 = nobody, 1 = instruction side, 2 = data side.
  int          m_own  = 0;
  int          m_last = 1;
  logic        m_wr   = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_mask = '0;

  function automatic int tie_winner(input int last);
`ifdef MEM_ARBITER_RR_EN
    return (last == 1) ? 2 : 1;
`else
    return 2;
`endif
  endfunction

  always @(negedge clk) begin
    bit ir, dr;
    int win;
    if (!rst_n) begin
      m_own = 0; m_last = 1; m_wr = 1'b0;
      m_addr = '0; m_wdata = '0; m_mask = '0;
    end
    chk("busy",      busy,                m_own != 0);
    chk("mem_read",  bus.mem_read,        (m_own != 0) && !m_wr);
    chk("mem_write", bus.mem_write,       (m_own != 0) && m_wr);
    chk("mem_addr",  bus.mem_address,     m_addr);
    chk("mem_wdata", bus.mem_wdata,       m_wdata);
    chk("mem_be",    bus.mem_byte_enable, m_mask);
    chk("i_resp",    bus.i_resp,          (m_own == 1) && bus.mem_resp);
    chk("d_resp",    bus.d_resp,          (m_own == 2) && bus.mem_resp);
    chk("i_rdata",   bus.i_rdata,         (m_own == 1) ? bus.mem_rdata : 32'h0);
    chk("d_rdata",   bus.d_rdata,         (m_own == 2) ? bus.mem_rdata : 32'h0);
    if (rst_n) begin
      if (m_own != 0) begin
        if (bus.mem_resp) m_own = 0;
      end else begin
        ir = bus.i_read | bus.i_write;
        dr = bus.d_read | bus.d_write;
        if (ir || dr) begin
          win = (ir && dr) ? tie_winner(m_last) : (dr ? 2 : 1);
          m_own = win; m_last = win;
          if (win == 2) begin
            m_wr = bus.d_write; m_addr = bus.d_addr; m_wdata = bus.d_wdata; m_mask = bus.d_wmask;
          end else begin
            m_wr = bus.i_write; m_addr = bus.i_addr; m_wdata = bus.i_wdata; m_mask = bus.i_wmask;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    bus.i_read = 0; bus.i_write = 0; bus.i_addr = '0; bus.i_wdata = '0; bus.i_wmask = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wmask = '0;
    bus.mem_resp = 0; bus.mem_rdata = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int got [4];
    int exp [4];
    rst_n = 1'b0;
    quiet();
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_addr", bus.mem_address, 0);
    rst_n = 1'b1;
    step();

    // Single read, memory responds on the third serve cycle.
    bus.i_read = 1; bus.i_addr = 32'h60;
    step();
    chk("rd_mem_read", bus.mem_read, 1);
    chk("rd_addr", bus.mem_address, 32'h60);
    step(); step();
    bus.mem_resp = 1; bus.mem_rdata = 32'hDEADBEEF; #1;
    chk("rd_i_resp", bus.i_resp, 1);
    chk("rd_i_rdata", bus.i_rdata, 32'hDEADBEEF);
    step();
    quiet(); #1;
    chk("rd_busy_after", busy, 0);
    chk("rd_i_resp_after", bus.i_resp, 0);

    // Data-side write.
    bus.d_write = 1; bus.d_addr = 32'h104; bus.d_wdata = 32'h12345678; bus.d_wmask = 4'b0011;
    step();
    chk("wr_mem_write", bus.mem_write, 1);
    chk("wr_be", bus.mem_byte_enable, 4'b0011);
    chk("wr_wdata", bus.mem_wdata, 32'h12345678);
    bus.mem_resp = 1; #1;
    chk("wr_d_resp", bus.d_resp, 1);
    chk("wr_i_resp", bus.i_resp, 0);
    step();
    quiet();
    step();

    // Requester address changes mid-serve.
    bus.i_read = 1; bus.i_addr = 32'h60;
    step();
    bus.i_addr = 32'h80;
    step();
    chk("mid_addr1", bus.mem_address, 32'h60);
    step();
    chk("mid_addr2", bus.mem_address, 32'h60);
    bus.mem_resp = 1;
    step();
    quiet();
    step();

    // Both sides held for four transactions.
    bus.i_read = 1; bus.i_addr = 32'h200; bus.d_read = 1; bus.d_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("tie_busy", busy, 1);
      got[k] = (bus.mem_address == 32'h300) ? 2 : 1;
      bus.mem_resp = 1;
      step();
      bus.mem_resp = 0;
      if (k == 3) begin bus.i_read = 0; bus.d_read = 0; end
    end
`ifdef MEM_ARBITER_RR_EN
    exp = '{2, 1, 2, 1};
`else
    exp = '{2, 2, 2, 2};
`endif
    for (int k = 0; k < 4; k++) chk("tie_order", got[k], exp[k]);
    quiet();
    step();

    // Reset while a read is in flight.
    bus.i_read = 1; bus.i_addr = 32'h60;
    step();
    chk("rs_mem_read_pre", bus.mem_read, 1);
    bus.mem_resp = 1;
    rst_n = 1'b0; #1;
    chk("rs_mem_read", bus.mem_read, 0);
    chk("rs_i_resp", bus.i_resp, 0);
    step();
    rst_n = 1'b1; bus.mem_resp = 0;
    step();
    chk("rs_regrant", bus.mem_read, 1);
    chk("rs_regrant_addr", bus.mem_address, 32'h60);
    bus.mem_resp = 1;
    step();
    quiet();
    step();

    // Stray response while idle.
    bus.mem_resp = 1; #1;
    chk("stray_i_resp", bus.i_resp, 0);
    chk("stray_d_resp", bus.d_resp, 0);
    step();
    chk("stray_busy", busy, 0);
    quiet();
    step();

    // Random traffic, including illegal read+write, dropped requests,
    // multi-cycle/stray responses and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst_n         = ($urandom_range(0, 299) != 0);
      bus.i_read    = ($urandom_range(0, 2) == 0);
      bus.i_write   = ($urandom_range(0, 4) == 0);
      bus.d_read    = ($urandom_range(0, 2) == 0);
      bus.d_write   = ($urandom_range(0, 4) == 0);
      bus.i_addr    = $urandom; bus.i_wdata = $urandom; bus.i_wmask = 4'($urandom);
      bus.d_addr    = $urandom; bus.d_wdata = $urandom; bus.d_wmask = 4'($urandom);
      bus.mem_resp  = ($urandom_range(0, 2) == 0);
      bus.mem_rdata = $urandom;
      step();
    end
    rst_n = 1'b1;
    quiet();
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
